neander_datapath: RTL and testbench

Datapath for the Neander processor, downstream of the control FSM. It takes the FSM's per-cycle control strobes (`selPC`, `enREM`, `write`, `selMEM`, `opULA`, `enAC`, `enPC`) and applies them to these elements:
- program counter (PC)
- memory address register (REM)
- 256×8 memory
- accumulator (AC)
- instruction register (RI)

It returns the current opcode nibble (`op3`..`op0`) to the FSM, closing the control loop. A preload port fills memory before execution.

---
 rtl/neander_datapath.sv | 187 ++++++++++++++++++
 tb/tb_neander_datapath.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/neander_datapath.sv
// -----------------------------------------------------------------------------
// neander_datapath
//
// Datapath of the Neander processor. It applies the control FSM's per-cycle
// strobes to the program counter (PC), the memory address register (REM), a
// 2^AW x DW memory, the accumulator (AC) and the instruction register (RI).
// It returns the opcode nibble to the FSM. A preload port fills memory before
// execution. The preload port keeps working while the core is held in reset.
//
// Ports:
//   clock                  system clock, all state changes on the rising edge
//   reset                  synchronous, active-low reset
//   selPC                  REM source select: 1 = PC, 0 = mem_q
//   enREM                  REM <- address mux
//   write                  mem[REM] <- AC
//   selMEM                 memory read address: 1 = REM, 0 = PC
//   opULA                  ALU op: 0 = pass mem_q, 1 = AC + mem_q
//   enAC                   AC (and flags) <- ALU result
//   enPC                   PC <- PC + 1
//   loadPC                 PC <- mem_q (jump), has priority over enPC
//   enRI                   RI <- mem_q
//   load_en/addr/data      preload write port, has priority over write
//   op3..op0               RI[7:4], MSB first
//   ac, pc                 register contents
//   mem_q                  combinational memory read data
//   flagN, flagZ           AC sign / zero flags
//
// Configuration macro:
//   NEANDER_NZ_FLAGS_EN    when defined, N/Z flag registers are built.
//                          When undefined, flagN and flagZ are tied to 0.
// -----------------------------------------------------------------------------
module neander_datapath #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          selPC,
    input  logic          enREM,
    input  logic          write,
    input  logic          selMEM,
    input  logic          opULA,
    input  logic          enAC,
    input  logic          enPC,
    input  logic          loadPC,
    input  logic          enRI,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    output logic          op3,
    output logic          op2,
    output logic          op1,
    output logic          op0,
    output logic [DW-1:0] ac,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] mem_q,
    output logic          flagN,
    output logic          flagZ
);

    // ALU: pass operand, or add it to AC with the carry discarded
    function automatic logic [DW-1:0] alu_f(input logic          op_add,
                                            input logic [DW-1:0] acc,
                                            input logic [DW-1:0] operand);
        logic [DW-1:0] res;
        if (op_add) begin
            res = acc + operand;
        end else begin
            res = operand;
        end
        return res;
    endfunction

    logic [DW-1:0] mem_r [0:(1<<AW)-1];
    logic [AW-1:0] pc_r;
    logic [AW-1:0] rem_r;
    logic [DW-1:0] ac_r;
    // Only the opcode nibble of RI is observable, so only it is stored
    logic [3:0]    ri_op_r;

    logic [AW-1:0] rd_addr_s;
    logic [DW-1:0] mem_q_s;
    logic [AW-1:0] mem_q_addr_s;
    logic [AW-1:0] rem_next_s;
    logic [DW-1:0] alu_s;

    // Read address mux, operand-as-address conversion, REM source mux and ALU
    always_comb begin
        rd_addr_s    = selMEM ? rem_r : pc_r;
        mem_q_s      = mem_r[rd_addr_s];
        mem_q_addr_s = AW'(mem_q_s);
        rem_next_s   = selPC ? pc_r : mem_q_addr_s;
        alu_s        = alu_f(opULA, ac_r, mem_q_s);
    end

    // Memory write port. Preload wins over a store and is honoured in reset.
    // Contents are deliberately not cleared by reset.
    always_ff @(posedge clock) begin
        if (load_en) begin
            mem_r[load_addr] <= load_data;
        end else if (reset && write) begin
            mem_r[rem_r] <= ac_r;
        end else begin
            mem_r[rem_r] <= mem_r[rem_r];
        end
    end

    // Program counter: jump has priority over increment; increment wraps
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_r <= {AW{1'b0}};
        end else if (loadPC) begin
            pc_r <= mem_q_addr_s;
        end else if (enPC) begin
            pc_r <= pc_r + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            pc_r <= pc_r;
        end
    end

    // Memory address register
    always_ff @(posedge clock) begin
        if (!reset) begin
            rem_r <= {AW{1'b0}};
        end else if (enREM) begin
            rem_r <= rem_next_s;
        end else begin
            rem_r <= rem_r;
        end
    end

    // Accumulator
    always_ff @(posedge clock) begin
        if (!reset) begin
            ac_r <= {DW{1'b0}};
        end else if (enAC) begin
            ac_r <= alu_s;
        end else begin
            ac_r <= ac_r;
        end
    end

    // Instruction register (opcode nibble)
    always_ff @(posedge clock) begin
        if (!reset) begin
            ri_op_r <= 4'b0000;
        end else if (enRI) begin
            ri_op_r <= mem_q_s[DW-1 -: 4];
        end else begin
            ri_op_r <= ri_op_r;
        end
    end

`ifdef NEANDER_NZ_FLAGS_EN
    logic flag_n_r;
    logic flag_z_r;

    // N/Z flags track the ALU result on every AC load; reset leaves AC = 0 so Z = 1
    always_ff @(posedge clock) begin
        if (!reset) begin
            flag_n_r <= 1'b0;
            flag_z_r <= 1'b1;
        end else if (enAC) begin
            flag_n_r <= alu_s[DW-1];
            flag_z_r <= (alu_s == {DW{1'b0}});
        end else begin
            flag_n_r <= flag_n_r;
            flag_z_r <= flag_z_r;
        end
    end

    assign flagN = flag_n_r;
    assign flagZ = flag_z_r;
`else
    assign flagN = 1'b0;
    assign flagZ = 1'b0;
`endif

    assign pc    = pc_r;
    assign ac    = ac_r;
    assign mem_q = mem_q_s;
    assign op3   = ri_op_r[3];
    assign op2   = ri_op_r[2];
    assign op1   = ri_op_r[1];
    assign op0   = ri_op_r[0];

endmodule

// File: tb/tb_neander_datapath.sv
// -----------------------------------------------------------------------------
// tb_neander_datapath
//
// Directed, self-checking bench for neander_datapath. A short program is
// preloaded under reset and then stepped by hand-driven control strobes.
// Expected values are hand-computed constants. Flag expectations follow
// NEANDER_NZ_FLAGS_EN: the flags read 0/0 when it is undefined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_neander_datapath;

`ifdef NEANDER_NZ_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       selPC, enREM, write, selMEM, opULA, enAC, enPC, loadPC, enRI;
    logic       load_en;
    logic [7:0] load_addr, load_data;
    logic       op3, op2, op1, op0;
    logic [7:0] ac, pc, mem_q;
    logic       flagN, flagZ;

    int errors = 0;
    int checks = 0;

    neander_datapath #(.AW(8), .DW(8)) dut (
        .clock(clock), .reset(reset),
        .selPC(selPC), .enREM(enREM), .write(write), .selMEM(selMEM),
        .opULA(opULA), .enAC(enAC), .enPC(enPC), .loadPC(loadPC), .enRI(enRI),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .op3(op3), .op2(op2), .op1(op1), .op0(op0),
        .ac(ac), .pc(pc), .mem_q(mem_q), .flagN(flagN), .flagZ(flagZ)
    );

    always #5 clock = ~clock;

    task automatic clear_strobes();
        selPC = 1'b0; enREM = 1'b0; write = 1'b0; selMEM = 1'b0; opULA = 1'b0;
        enAC = 1'b0; enPC = 1'b0; loadPC = 1'b0; enRI = 1'b0;
        load_en = 1'b0; load_addr = 8'h00; load_data = 8'h00;
    endtask

    // One rising edge, then release strobes and let outputs settle
    task automatic tick();
        @(posedge clock);
        #1;
        clear_strobes();
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
    endtask

    task automatic fetch();
        selPC = 1'b1; enREM = 1'b1;
        tick();
        selMEM = 1'b1; enRI = 1'b1; enPC = 1'b1;
        tick();
    endtask

    // Operand fetch through REM then ALU into AC
    task automatic exec_operand(input logic add);
        selPC = 1'b1; enREM = 1'b1;
        tick();
        selMEM = 1'b1; selPC = 1'b0; enREM = 1'b1; enPC = 1'b1;
        tick();
        selMEM = 1'b1; opULA = add; enAC = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            {selPC, enREM, write, selMEM, opULA, enAC, enPC, loadPC, enRI} = 9'($urandom);
            tick();
        end
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 8'h00); end
        checks++; if (ac !== 8'h00) begin errors++; $display("FAIL reset_ac: got %h expected %h", ac, 8'h00); end
        checks++; if ({op3, op2, op1, op0} !== 4'b0000) begin errors++; $display("FAIL reset_op: got %b expected 0000", {op3, op2, op1, op0}); end
        checks++; if ({flagN, flagZ} !== {1'b0, FLAGS_EN}) begin errors++; $display("FAIL reset_flags: got %b expected %b", {flagN, flagZ}, {1'b0, FLAGS_EN}); end
    endtask

    task automatic test_preload_fetch();
        preload(8'h00, 8'h20); preload(8'h01, 8'h80); preload(8'h80, 8'hF0);
        preload(8'h02, 8'h30); preload(8'h03, 8'h81); preload(8'h81, 8'h10);
        preload(8'h04, 8'h82); preload(8'h05, 8'h90); preload(8'h82, 8'h5A);
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL preload_pc_held: got %h expected %h", pc, 8'h00); end
        reset = 1'b1;
        fetch();
        checks++; if ({op3, op2, op1, op0} !== 4'b0010) begin errors++; $display("FAIL fetch_op: got %b expected 0010", {op3, op2, op1, op0}); end
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL fetch_pc: got %h expected %h", pc, 8'h01); end
    endtask

    task automatic test_lda_add();
        exec_operand(1'b0);
        checks++; if (ac !== 8'hF0) begin errors++; $display("FAIL lda_ac: got %h expected %h", ac, 8'hF0); end
        checks++; if (pc !== 8'h02) begin errors++; $display("FAIL lda_pc: got %h expected %h", pc, 8'h02); end
        checks++; if ({flagN, flagZ} !== {FLAGS_EN, 1'b0}) begin errors++; $display("FAIL lda_flags: got %b expected %b", {flagN, flagZ}, {FLAGS_EN, 1'b0}); end
        fetch();
        checks++; if ({op3, op2, op1, op0} !== 4'b0011) begin errors++; $display("FAIL add_fetch_op: got %b expected 0011", {op3, op2, op1, op0}); end
        exec_operand(1'b1);
        checks++; if (ac !== 8'h00) begin errors++; $display("FAIL add_wrap_ac: got %h expected %h", ac, 8'h00); end
        checks++; if ({flagN, flagZ} !== {1'b0, FLAGS_EN}) begin errors++; $display("FAIL add_flags: got %b expected %b", {flagN, flagZ}, {1'b0, FLAGS_EN}); end
        checks++; if (pc !== 8'h04) begin errors++; $display("FAIL add_pc: got %h expected %h", pc, 8'h04); end
    endtask

    task automatic test_sta_priority();
        enREM = 1'b1;                                    // REM <- mem[4] = 0x82
        tick();
        selMEM = 1'b1; enAC = 1'b1; enPC = 1'b1;         // AC <- 0x5A, PC <- 5
        tick();
        checks++; if (ac !== 8'h5A) begin errors++; $display("FAIL sta_ac: got %h expected %h", ac, 8'h5A); end
        checks++; if ({flagN, flagZ} !== 2'b00) begin errors++; $display("FAIL sta_flags: got %b expected 00", {flagN, flagZ}); end
        enREM = 1'b1;                                    // REM <- mem[5] = 0x90
        tick();
        write = 1'b1;
        tick();
        selMEM = 1'b1; #1;
        checks++; if (mem_q !== 8'h5A) begin errors++; $display("FAIL sta_store: got %h expected %h", mem_q, 8'h5A); end
        write = 1'b1; load_en = 1'b1; load_addr = 8'h90; load_data = 8'h11;
        tick();
        selMEM = 1'b1; #1;
        checks++; if (mem_q !== 8'h11) begin errors++; $display("FAIL load_priority: got %h expected %h", mem_q, 8'h11); end
        write = 1'b1; enAC = 1'b1; opULA = 1'b1;         // stores old AC, AC <- 0x5A + 0x11
        tick();
        selMEM = 1'b1; #1;
        checks++; if (mem_q !== 8'h5A) begin errors++; $display("FAIL write_old_ac: got %h expected %h", mem_q, 8'h5A); end
        checks++; if (ac !== 8'h6B) begin errors++; $display("FAIL add_after_store: got %h expected %h", ac, 8'h6B); end
        write = 1'b1; enREM = 1'b1; selPC = 1'b1;        // stores to old REM 0x90, REM <- 5
        tick();
        selMEM = 1'b1; #1;
        checks++; if (mem_q !== 8'h90) begin errors++; $display("FAIL rem_moved: got %h expected %h", mem_q, 8'h90); end
        selMEM = 1'b1; enREM = 1'b1;                     // REM <- mem[5] = 0x90
        tick();
        selMEM = 1'b1; #1;
        checks++; if (mem_q !== 8'h6B) begin errors++; $display("FAIL write_old_rem: got %h expected %h", mem_q, 8'h6B); end
    endtask

    task automatic test_pc();
        preload(8'h90, 8'hFF);
        selMEM = 1'b1; loadPC = 1'b1;
        tick();
        checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL jump_ff: got %h expected %h", pc, 8'hFF); end
        enPC = 1'b1;
        tick();
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL pc_wrap: got %h expected %h", pc, 8'h00); end
        tick();
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL pc_hold: got %h expected %h", pc, 8'h00); end
        preload(8'h90, 8'h42);
        selMEM = 1'b1; loadPC = 1'b1; enPC = 1'b1;
        tick();
        checks++; if (pc !== 8'h42) begin errors++; $display("FAIL jump_priority: got %h expected %h", pc, 8'h42); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b0; enAC = 1'b1; opULA = 1'b1; selMEM = 1'b1; enPC = 1'b1; enRI = 1'b1;
        tick();
        checks++; if (ac !== 8'h00) begin errors++; $display("FAIL mid_reset_ac: got %h expected %h", ac, 8'h00); end
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL mid_reset_pc: got %h expected %h", pc, 8'h00); end
        checks++; if ({op3, op2, op1, op0} !== 4'b0000) begin errors++; $display("FAIL mid_reset_op: got %b expected 0000", {op3, op2, op1, op0}); end
        checks++; if ({flagN, flagZ} !== {1'b0, FLAGS_EN}) begin errors++; $display("FAIL mid_reset_flags: got %b expected %b", {flagN, flagZ}, {1'b0, FLAGS_EN}); end
        reset = 1'b1; #1;
        checks++; if (mem_q !== 8'h20) begin errors++; $display("FAIL mem_kept_0: got %h expected %h", mem_q, 8'h20); end
        enPC = 1'b1;
        tick();
        checks++; if (mem_q !== 8'h80) begin errors++; $display("FAIL mem_kept_1: got %h expected %h", mem_q, 8'h80); end
        enREM = 1'b1;                                    // REM <- mem[1] = 0x80
        tick();
        selMEM = 1'b1; #1;
        checks++; if (mem_q !== 8'hF0) begin errors++; $display("FAIL mem_kept_80: got %h expected %h", mem_q, 8'hF0); end
    endtask

    initial begin
        clear_strobes();
        reset = 1'b0;
        #2;
        test_reset();
        test_preload_fetch();
        test_lda_add();
        test_sta_priority();
        test_pc();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
